// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: FSM state encoding and ALU operation codes.
package calc_pkg;

    typedef enum logic [1:0] {
        GET_A = 2'd0,
        GET_B = 2'd1,
        EXEC  = 2'd2,
        SHOW  = 2'd3
    } state_e;

    localparam logic [1:0] FUNC_ADD  = 2'b00;
    localparam logic [1:0] FUNC_SUB  = 2'b01;
    localparam logic [1:0] FUNC_MUL  = 2'b10;
    localparam logic [1:0] FUNC_PASS = 2'b11;

endpackage

// File: rtl/blink_timer.sv
// Free-running half-period counter for the error blink; held at zero while disabled.
module blink_timer #(
    parameter int unsigned blink_cycles = 12500000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic toggle
);

    localparam int unsigned CW = (blink_cycles > 1) ? $clog2(blink_cycles) : 1;
    localparam logic [CW-1:0] LAST = CW'(blink_cycles - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Pulses for one cycle on the wrap edge so the parent flips its blank flag there.
    assign toggle = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = '0;
        if (en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/calc_seq.sv
// Operand-entry sequencer for a switch/key calculator: captures A, B and the operation,
// latches the external ALU result for one EXEC cycle, and drives the display.
module calc_seq
    import calc_pkg::*;
#(
    parameter int unsigned width        = 6,
    parameter int unsigned blink_cycles = 12500000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_enter,
    input  logic [width-1:0]     sw_val,
    input  logic [2:0]           sw_func,
    output logic [width-1:0]     alu_a,
    output logic [width-1:0]     alu_b,
    output logic [1:0]           alu_func,
    input  logic [2*width-1:0]   alu_result,
    input  logic                 alu_ovf,
    output logic [2*width-1:0]   disp_val,
    output logic                 disp_sel,
    output logic                 disp_blank,
    output logic                 err,
    output logic                 busy
);

    state_e               state_q, state_d;
    logic [width-1:0]     a_q, a_d;
    logic [width-1:0]     b_q, b_d;
    logic [1:0]           func_q, func_d;
    logic [2*width-1:0]   result_q, result_d;
    logic                 err_q, err_d;
    logic                 blank_q, blank_d;
    logic                 busy_q, busy_d;
    logic                 blink_en;
    logic                 blink_tgl;

    // Leaving SHOW on enter also resets the counter on that same edge.
    assign blink_en = (state_q == SHOW) && err_q && !key_enter;

    blink_timer #(
        .blink_cycles(blink_cycles)
    ) u_blink (
        .clk    (clk),
        .rst    (rst),
        .en     (blink_en),
        .toggle (blink_tgl)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        func_d   = func_q;
        result_d = result_q;
        err_d    = err_q;
        blank_d  = 1'b0;
        unique case (state_q)
            GET_A: begin
                if (key_enter) begin
                    a_d     = sw_val;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                if (key_enter) begin
                    b_d     = sw_val;
                    func_d  = sw_func[1:0];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_result;
                err_d    = alu_ovf;
                state_d  = SHOW;
            end
            SHOW: begin
                if (key_enter) begin
                    err_d   = 1'b0;
                    state_d = GET_A;
                end else begin
                    blank_d = blink_tgl ? ~blank_q : blank_q;
                end
            end
            default: state_d = GET_A;
        endcase
        busy_d = (state_d == EXEC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= GET_A;
            a_q      <= '0;
            b_q      <= '0;
            func_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            blank_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            func_q   <= func_d;
            result_q <= result_d;
            err_q    <= err_d;
            blank_q  <= blank_d;
            busy_q   <= busy_d;
        end
    end

    // Live switch value is shown in place of the operand currently being entered.
    always_comb begin
        disp_val = {a_q, b_q};
        disp_sel = 1'b0;
        unique case (state_q)
            GET_A: disp_val = {sw_val, b_q};
            GET_B: disp_val = {a_q, sw_val};
            EXEC:  disp_val = {a_q, b_q};
            SHOW: begin
                if (!sw_func[2]) begin
                    disp_val = result_q;
                    disp_sel = 1'b1;
                end
            end
            default: disp_val = {a_q, b_q};
        endcase
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_func   = func_q;
    assign err        = err_q;
    assign disp_blank = blank_q;
    assign busy       = busy_q;

endmodule
